// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issues one operand triple to a fixed-latency FPU core,
// captures the result after LATENCY cycles, and holds it until consumed.
// Sticky exception flags accumulate across operations.
module fpu_op_sequencer #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned CANON_NAN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_c,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [31:0] fpu_c,
    input  logic [31:0] fpu_o,
    input  logic        fpu_nv,
    input  logic        fpu_dz,
    input  logic        fpu_of,
    input  logic        fpu_uf,
    input  logic        fpu_nx,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_o,
    output logic [4:0]  resp_flags,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter is loaded with LATENCY-1 so that capture lands LATENCY edges after accept.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 32'd1);

    // Replace any NaN with the canonical quiet NaN when enabled.
    function automatic logic [31:0] canon_result(input logic [31:0] o);
        logic [31:0] r;
        if ((CANON_NAN != 32'd0) && (o[30:23] == 8'hff) && (o[22:0] != 23'd0)) begin
            r = 32'h7fc00000;
        end else begin
            r = o;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] fpu_a_q, fpu_a_d;
    logic [31:0] fpu_b_q, fpu_b_d;
    logic [31:0] fpu_c_q, fpu_c_d;
    logic [31:0] resp_o_q, resp_o_d;
    logic [4:0]  resp_flags_q, resp_flags_d;
    logic [4:0]  fflags_q, fflags_d;
    logic        capture_s;
    logic [4:0]  core_flags_s;

    assign core_flags_s = {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};

    // Next-state, counter, operand latch and result capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        fpu_c_d      = fpu_c_q;
        resp_o_d     = resp_o_q;
        resp_flags_d = resp_flags_q;
        capture_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    fpu_a_d = req_a;
                    fpu_b_d = req_b;
                    fpu_c_d = req_c;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    capture_s    = 1'b1;
                    resp_o_d     = canon_result(fpu_o);
                    resp_flags_d = core_flags_s;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Sticky flags: a clear wipes the old value first, then a capture on the same edge sets.
    always_comb begin
        fflags_d = fflags_clr ? 5'd0 : fflags_q;
        if (capture_s) begin
            fflags_d = fflags_d | core_flags_s;
        end else begin
            fflags_d = fflags_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            fpu_a_q      <= 32'd0;
            fpu_b_q      <= 32'd0;
            fpu_c_q      <= 32'd0;
            resp_o_q     <= 32'd0;
            resp_flags_q <= 5'd0;
            fflags_q     <= 5'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            fpu_c_q      <= fpu_c_d;
            resp_o_q     <= resp_o_d;
            resp_flags_q <= resp_flags_d;
            fflags_q     <= fflags_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP) && !rst;
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_c      = fpu_c_q;
    assign resp_o     = resp_o_q;
    assign resp_flags = resp_flags_q;
    assign fflags     = fflags_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Testbench for fpu_op_sequencer: three instances (LATENCY 2/1/15, NaN
// canonicalisation on/off) driven with shared stimulus and checked every
// cycle against a transaction-level reference model.
module tb_fpu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_a = 32'd0, req_b = 32'd0, req_c = 32'd0;
    logic [31:0] fpu_o = 32'd0;
    logic [4:0]  core_flags = 5'd0;
    logic        resp_ready = 1'b0;
    logic        fflags_clr = 1'b0;

    logic [2:0]       req_ready_w, resp_valid_w;
    logic [2:0][31:0] fpu_a_w, fpu_b_w, fpu_c_w, resp_o_w;
    logic [2:0][4:0]  resp_flags_w, fflags_w;

    int lat_m [3] = '{2, 1, 15};
    int can_m [3] = '{1, 0, 1};

    logic [31:0] exp_o  [3];
    logic [4:0]  exp_fl [3];
    logic [4:0]  exp_ff [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpu_op_sequencer #(.LATENCY(2), .CANON_NAN(1)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w[0]),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .fpu_a(fpu_a_w[0]), .fpu_b(fpu_b_w[0]), .fpu_c(fpu_c_w[0]), .fpu_o(fpu_o),
        .fpu_nv(core_flags[4]), .fpu_dz(core_flags[3]), .fpu_of(core_flags[2]),
        .fpu_uf(core_flags[1]), .fpu_nx(core_flags[0]),
        .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready), .resp_o(resp_o_w[0]),
        .resp_flags(resp_flags_w[0]), .fflags(fflags_w[0]), .fflags_clr(fflags_clr));

    fpu_op_sequencer #(.LATENCY(1), .CANON_NAN(0)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w[1]),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .fpu_a(fpu_a_w[1]), .fpu_b(fpu_b_w[1]), .fpu_c(fpu_c_w[1]), .fpu_o(fpu_o),
        .fpu_nv(core_flags[4]), .fpu_dz(core_flags[3]), .fpu_of(core_flags[2]),
        .fpu_uf(core_flags[1]), .fpu_nx(core_flags[0]),
        .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready), .resp_o(resp_o_w[1]),
        .resp_flags(resp_flags_w[1]), .fflags(fflags_w[1]), .fflags_clr(fflags_clr));

    fpu_op_sequencer #(.LATENCY(15), .CANON_NAN(1)) u_l15 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w[2]),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .fpu_a(fpu_a_w[2]), .fpu_b(fpu_b_w[2]), .fpu_c(fpu_c_w[2]), .fpu_o(fpu_o),
        .fpu_nv(core_flags[4]), .fpu_dz(core_flags[3]), .fpu_of(core_flags[2]),
        .fpu_uf(core_flags[1]), .fpu_nx(core_flags[0]),
        .resp_valid(resp_valid_w[2]), .resp_ready(resp_ready), .resp_o(resp_o_w[2]),
        .resp_flags(resp_flags_w[2]), .fflags(fflags_w[2]), .fflags_clr(fflags_clr));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] o, input int canon);
        if (canon != 0 && o[30:23] == 8'hff && o[22:0] != 23'd0) return 32'h7fc00000;
        return o;
    endfunction

    function automatic logic [31:0] rand_result();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[30:23] = 8'hff;                                  // NaN unless mantissa is zero
            1: begin r[30:23] = 8'hff; r[22:0] = 23'd0; end       // infinity
            2: begin r[30:23] = 8'hff; r[22:0] = 23'd1; end       // smallest-payload sNaN
            default: r = r;
        endcase
        return r;
    endfunction

    // Apply one clock edge to the model: clear first, capture where latency elapses.
    task automatic model_edge(input int k, input logic [31:0] o, input logic [4:0] f, input bit clr);
        for (int i = 0; i < 3; i++) begin
            if (clr) exp_ff[i] = 5'd0;
            if (k == lat_m[i]) begin
                exp_o[i]  = ref_result(o, can_m[i]);
                exp_fl[i] = f;
                exp_ff[i] = exp_ff[i] | f;
            end
        end
    endtask

    task automatic check_cycle(input int k, input logic [31:0] a, b, c);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("d%0d k%0d resp_valid", i, k), resp_valid_w[i], (k >= lat_m[i]) ? 1 : 0);
            check_eq($sformatf("d%0d k%0d req_ready", i, k), req_ready_w[i], 32'd0);
            check_eq($sformatf("d%0d k%0d fpu_a", i, k), fpu_a_w[i], a);
            check_eq($sformatf("d%0d k%0d fpu_b", i, k), fpu_b_w[i], b);
            check_eq($sformatf("d%0d k%0d fpu_c", i, k), fpu_c_w[i], c);
            check_eq($sformatf("d%0d k%0d fflags", i, k), fflags_w[i], exp_ff[i]);
            if (k >= lat_m[i]) begin
                check_eq($sformatf("d%0d k%0d resp_o", i, k), resp_o_w[i], exp_o[i]);
                check_eq($sformatf("d%0d k%0d resp_flags", i, k), resp_flags_w[i], exp_fl[i]);
            end
        end
    endtask

    // One full operation: accept, run until every instance responds, hold, consume.
    task automatic run_op(input logic [31:0] a, b, c, input bit fixed, input logic [31:0] o_fix,
                          input logic [4:0] f_fix, input int clr_edge, input int extra);
        logic [31:0] o_now;
        logic [4:0]  f_now;
        for (int i = 0; i < 3; i++) check_eq($sformatf("d%0d idle req_ready", i), req_ready_w[i], 32'd1);
        req_valid  = 1'b1;
        req_a = a; req_b = b; req_c = c;
        o_now = fixed ? o_fix : rand_result();
        f_now = fixed ? f_fix : 5'($urandom);
        fpu_o = o_now; core_flags = f_now;
        fflags_clr = (clr_edge == 0);
        step();
        model_edge(0, o_now, f_now, clr_edge == 0);
        check_cycle(0, a, b, c);
        for (int k = 1; k <= 15 + extra; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_a = $urandom; req_b = $urandom; req_c = $urandom;
            o_now = fixed ? o_fix : rand_result();
            f_now = fixed ? f_fix : 5'($urandom);
            fpu_o = o_now; core_flags = f_now;
            fflags_clr = (k == clr_edge);
            step();
            model_edge(k, o_now, f_now, k == clr_edge);
            check_cycle(k, a, b, c);
        end
        // Consume edge: a request offered here must not be taken.
        resp_ready = 1'b1; fflags_clr = 1'b0;
        req_valid = 1'b1; req_a = ~a; req_b = ~b; req_c = ~c;
        step();
        resp_ready = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("d%0d consume req_ready", i), req_ready_w[i], 32'd1);
            check_eq($sformatf("d%0d consume resp_valid", i), resp_valid_w[i], 32'd0);
            check_eq($sformatf("d%0d consume fpu_a", i), fpu_a_w[i], a);
            check_eq($sformatf("d%0d consume fflags", i), fflags_w[i], exp_ff[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            exp_o[i] = 32'd0; exp_fl[i] = 5'd0; exp_ff[i] = 5'd0;
        end
        // Reset state
        step(); step();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("d%0d rst req_ready", i), req_ready_w[i], 32'd0);
            check_eq($sformatf("d%0d rst resp_valid", i), resp_valid_w[i], 32'd0);
            check_eq($sformatf("d%0d rst fpu_a", i), fpu_a_w[i], 32'd0);
            check_eq($sformatf("d%0d rst resp_o", i), resp_o_w[i], 32'd0);
            check_eq($sformatf("d%0d rst resp_flags", i), resp_flags_w[i], 32'd0);
            check_eq($sformatf("d%0d rst fflags", i), fflags_w[i], 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check_eq($sformatf("d%0d post-rst req_ready", i), req_ready_w[i], 32'd1);

        // Directed: plain add result, then NaN canonicalisation
        run_op(32'h3f800000, 32'h40000000, 32'd0, 1'b1, 32'h40400000, 5'b00000, -1, 0);
        run_op(32'h7f800001, 32'h3f800000, 32'd0, 1'b1, 32'h7fa00001, 5'b10000, -1, 0);
        check_eq("canon resp_o", resp_o_w[0], 32'h7fc00000);
        check_eq("raw resp_o", resp_o_w[1], 32'h7fa00001);
        check_eq("nan fflags", fflags_w[0], 32'h10);
        // Sticky accumulation, then clear coinciding with capture
        run_op(32'h1, 32'h2, 32'h3, 1'b1, 32'h3f000000, 5'b00101, 0, 0);
        run_op(32'h4, 32'h5, 32'h6, 1'b1, 32'h3e000000, 5'b01000, -1, 0);
        check_eq("sticky fflags", fflags_w[0], 32'h0d);
        run_op(32'h7, 32'h8, 32'h9, 1'b1, 32'h3d000000, 5'b01000, 2, 0);
        check_eq("clr+capture fflags", fflags_w[0], 32'h08);
        // Response held with resp_ready low for 5 extra cycles
        run_op(32'hcafef00d, 32'h12345678, 32'h9abcdef0, 1'b0, 32'd0, 5'd0, -1, 5);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            run_op($urandom, $urandom, $urandom, 1'b0, 32'd0, 5'd0,
                   int'($urandom_range(0, 20)) - 1, int'($urandom_range(0, 3)));
        end

        // Reset one cycle after accept discards the operation
        run_op(32'h1, 32'h1, 32'h1, 1'b1, 32'h7fffffff, 5'b11111, -1, 0);
        req_valid = 1'b1; req_a = 32'h11111111; req_b = 32'h22222222; req_c = 32'h33333333;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("d%0d inrst req_ready", i), req_ready_w[i], 32'd0);
            check_eq($sformatf("d%0d inrst resp_valid", i), resp_valid_w[i], 32'd0);
        end
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("d%0d midrst fpu_a", i), fpu_a_w[i], 32'd0);
            check_eq($sformatf("d%0d midrst resp_o", i), resp_o_w[i], 32'd0);
            check_eq($sformatf("d%0d midrst resp_flags", i), resp_flags_w[i], 32'd0);
            check_eq($sformatf("d%0d midrst fflags", i), fflags_w[i], 32'd0);
            check_eq($sformatf("d%0d midrst req_ready", i), req_ready_w[i], 32'd1);
        end
        for (int k = 0; k < 16; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("d%0d quiet resp_valid", i), resp_valid_w[i], 32'd0);
                check_eq($sformatf("d%0d quiet req_ready", i), req_ready_w[i], 32'd1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
